// File: rtl/capture_pkg.sv
// ============================================================================
// Module   : capture_pkg
// Brief    : Shared defaults and FSM encoding for the capture scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package capture_pkg;
  localparam int CANALES_DEF = 4;
  localparam int ANCHO_DEF   = 8;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PRESENT = 1'b1;
endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick, searching from last served + 1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import capture_pkg::*;
#(
  parameter int CANALES = CANALES_DEF
) (
  input  logic [CANALES-1:0]         ivReq,
  input  logic [$clog2(CANALES)-1:0] ivUltimo,
  output logic                       oValido,
  output logic [$clog2(CANALES)-1:0] ovIndice
);

  localparam int IW = $clog2(CANALES);

  logic [IW-1:0] w_idx;

  // Walk offsets from farthest to nearest so the nearest requester is written last.
  always_comb begin
    oValido  = 1'b0;
    ovIndice = '0;
    w_idx    = '0;
    for (int i = CANALES - 1; i >= 0; i--) begin
      w_idx = IW'((int'(ivUltimo) + 1 + i) % CANALES);
      if (ivReq[w_idx]) begin
        oValido  = 1'b1;
        ovIndice = w_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/capture_scheduler.sv
// ============================================================================
// Module   : capture_scheduler
// Brief    : Per-channel edge timestamp capture with round-robin presentation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module capture_scheduler
  import capture_pkg::*;
#(
  parameter int CANALES = CANALES_DEF,
  parameter int ANCHO   = ANCHO_DEF
) (
  input  logic                       iClk,
  input  logic                       iReset,
  input  logic [CANALES-1:0]         ivEstimulo,
  input  logic [CANALES-1:0]         ivHabilita,
  input  logic [ANCHO-1:0]           ivCuenta,
  input  logic                       iAck,
  input  logic                       iLimpiaOverrun,
  output logic [ANCHO-1:0]           ovCaptura,
  output logic [$clog2(CANALES)-1:0] ovCanal,
  output logic                       oCapturaFlag,
  output logic [CANALES-1:0]         ovPendiente,
  output logic [CANALES-1:0]         ovOverrun
);

  localparam int IW = $clog2(CANALES);

  logic [0:0]         r_state;
  logic [0:0]         w_stateNext;
  logic [CANALES-1:0] r_hist;
  logic [CANALES-1:0] r_pend;
  logic [CANALES-1:0] r_ovr;
  logic [CANALES-1:0] w_edge;
  logic [CANALES-1:0] w_granting;
  logic [CANALES-1:0] w_store;
  logic [CANALES-1:0] w_pendNext;
  logic [CANALES-1:0] w_ovrNext;
  logic [ANCHO-1:0]   r_slot [CANALES];
  logic [IW-1:0]      r_last;
  logic [IW-1:0]      w_gntIdx;
  logic               w_gntValid;
  logic               w_grantFire;

  assign w_edge      = ivEstimulo & ~r_hist & ivHabilita;
  assign ovPendiente = r_pend;
  assign ovOverrun   = r_ovr;

  rr_arbiter #(
    .CANALES (CANALES)
  ) uArbiter (
    .ivReq    (r_pend),
    .ivUltimo (r_last),
    .oValido  (w_gntValid),
    .ovIndice (w_gntIdx)
  );

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) r_state <= ST_IDLE;
    else        r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE:    if (w_gntValid) w_stateNext = ST_PRESENT;
      ST_PRESENT: if (iAck)       w_stateNext = ST_IDLE;
      default:                    w_stateNext = ST_IDLE;
    endcase
  end

  always_comb begin
    w_grantFire  = (r_state == ST_IDLE) && w_gntValid;
    oCapturaFlag = (r_state == ST_PRESENT);
  end

  // A channel being granted frees its slot this edge, so a coincident edge refills it cleanly.
  generate
    for (genvar k = 0; k < CANALES; k++) begin : g_canal
      assign w_granting[k] = w_grantFire && (w_gntIdx == IW'(k));
      assign w_store[k]    = w_edge[k] && (!r_pend[k] || w_granting[k]);
      assign w_pendNext[k] = w_store[k] || (r_pend[k] && !w_granting[k]);
      assign w_ovrNext[k]  = (w_edge[k] && r_pend[k] && !w_granting[k]) ||
                             (r_ovr[k] && !iLimpiaOverrun);
    end
  endgenerate

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_hist    <= '0;
      r_pend    <= '0;
      r_ovr     <= '0;
      r_last    <= IW'(CANALES - 1);
      ovCaptura <= '0;
      ovCanal   <= '0;
      for (int k = 0; k < CANALES; k++) r_slot[k] <= '0;
    end else begin
      r_hist <= ivEstimulo;
      r_pend <= w_pendNext;
      r_ovr  <= w_ovrNext;
      for (int k = 0; k < CANALES; k++) begin
        if (w_store[k]) r_slot[k] <= ivCuenta;
      end
      if (w_grantFire) begin
        ovCaptura <= r_slot[w_gntIdx];
        ovCanal   <= w_gntIdx;
        r_last    <= w_gntIdx;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_capture_scheduler.sv
// ============================================================================
// Module   : tb_capture_scheduler
// Brief    : Directed self-checking bench for capture_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_capture_scheduler;

  logic       iClk;
  logic       iReset;
  logic [3:0] ivEstimulo;
  logic [3:0] ivHabilita;
  logic [7:0] ivCuenta;
  logic       iAck;
  logic       iLimpiaOverrun;
  logic [7:0] ovCaptura;
  logic [1:0] ovCanal;
  logic       oCapturaFlag;
  logic [3:0] ovPendiente;
  logic [3:0] ovOverrun;

  int nCmp = 0;
  int nErr = 0;

  capture_scheduler #(.CANALES(4), .ANCHO(8)) dut (
    .iClk           (iClk),
    .iReset         (iReset),
    .ivEstimulo     (ivEstimulo),
    .ivHabilita     (ivHabilita),
    .ivCuenta       (ivCuenta),
    .iAck           (iAck),
    .iLimpiaOverrun (iLimpiaOverrun),
    .ovCaptura      (ovCaptura),
    .ovCanal        (ovCanal),
    .oCapturaFlag   (oCapturaFlag),
    .ovPendiente    (ovPendiente),
    .ovOverrun      (ovOverrun)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic doReset();
    ivEstimulo = 4'b0000; iAck = 1'b0; iLimpiaOverrun = 1'b0; ivHabilita = 4'b1111;
    iReset = 1'b1;
    tick();
    iReset = 1'b0;
  endtask

  task automatic test_reset();
    ivEstimulo = 4'b0000; ivHabilita = 4'b1111; ivCuenta = 8'h00;
    iAck = 1'b0; iLimpiaOverrun = 1'b0; iReset = 1'b1;
    #2;
    nCmp++; if (oCapturaFlag !== 1'b0) begin nErr++; $display("FAIL reset_flag: got %h expected 0", oCapturaFlag); end
    nCmp++; if (ovCaptura !== 8'h00) begin nErr++; $display("FAIL reset_captura: got %h expected 00", ovCaptura); end
    nCmp++; if (ovCanal !== 2'd0) begin nErr++; $display("FAIL reset_canal: got %h expected 0", ovCanal); end
    nCmp++; if (ovPendiente !== 4'b0000) begin nErr++; $display("FAIL reset_pend: got %b expected 0000", ovPendiente); end
    nCmp++; if (ovOverrun !== 4'b0000) begin nErr++; $display("FAIL reset_ovr: got %b expected 0000", ovOverrun); end
    tick();
    iReset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    ivCuenta = 8'h37; ivEstimulo = 4'b0100;
    tick();
    nCmp++; if (ovPendiente !== 4'b0100) begin nErr++; $display("FAIL single_pend: got %b expected 0100", ovPendiente); end
    nCmp++; if (oCapturaFlag !== 1'b0) begin nErr++; $display("FAIL single_early: got %h expected 0", oCapturaFlag); end
    ivCuenta = 8'h38;
    tick();
    nCmp++; if (oCapturaFlag !== 1'b1) begin nErr++; $display("FAIL single_flag: got %h expected 1", oCapturaFlag); end
    nCmp++; if (ovCanal !== 2'd2) begin nErr++; $display("FAIL single_canal: got %h expected 2", ovCanal); end
    nCmp++; if (ovCaptura !== 8'h37) begin nErr++; $display("FAIL single_captura: got %h expected 37", ovCaptura); end
    nCmp++; if (ovPendiente !== 4'b0000) begin nErr++; $display("FAIL single_pend_clr: got %b expected 0000", ovPendiente); end
    ivEstimulo = 4'b0000;
    tick(); tick();
    nCmp++; if (oCapturaFlag !== 1'b1 || ovCaptura !== 8'h37) begin nErr++; $display("FAIL single_hold: got %h/%h expected 1/37", oCapturaFlag, ovCaptura); end
    iAck = 1'b1;
    tick();
    iAck = 1'b0;
    nCmp++; if (oCapturaFlag !== 1'b0) begin nErr++; $display("FAIL single_ack: got %h expected 0", oCapturaFlag); end
    iAck = 1'b1;
    tick();
    iAck = 1'b0;
    nCmp++; if (oCapturaFlag !== 1'b0 || ovPendiente !== 4'b0000) begin nErr++; $display("FAIL idle_ack: got %h/%b expected 0/0000", oCapturaFlag, ovPendiente); end
  endtask

  task automatic test_simultaneous();
    doReset();
    ivCuenta = 8'h10; ivEstimulo = 4'b1001;
    tick();
    nCmp++; if (ovPendiente !== 4'b1001) begin nErr++; $display("FAIL simul_pend: got %b expected 1001", ovPendiente); end
    ivCuenta = 8'h11; ivEstimulo = 4'b0000;
    tick();
    nCmp++; if (oCapturaFlag !== 1'b1 || ovCanal !== 2'd0 || ovCaptura !== 8'h10) begin nErr++; $display("FAIL simul_first: got %h/%h/%h expected 1/0/10", oCapturaFlag, ovCanal, ovCaptura); end
    iAck = 1'b1;
    tick();
    iAck = 1'b0;
    nCmp++; if (oCapturaFlag !== 1'b0) begin nErr++; $display("FAIL simul_gap: got %h expected 0", oCapturaFlag); end
    tick();
    nCmp++; if (oCapturaFlag !== 1'b1 || ovCanal !== 2'd3 || ovCaptura !== 8'h10) begin nErr++; $display("FAIL simul_second: got %h/%h/%h expected 1/3/10", oCapturaFlag, ovCanal, ovCaptura); end
    iAck = 1'b1;
    tick();
    iAck = 1'b0;
  endtask

  task automatic test_overrun();
    ivCuenta = 8'h05; ivEstimulo = 4'b0010;
    tick();
    ivEstimulo = 4'b0000;
    tick();
    nCmp++; if (oCapturaFlag !== 1'b1 || ovCanal !== 2'd1 || ovCaptura !== 8'h05) begin nErr++; $display("FAIL ovr_first: got %h/%h/%h expected 1/1/05", oCapturaFlag, ovCanal, ovCaptura); end
    ivCuenta = 8'h20; ivEstimulo = 4'b0010;
    tick();
    nCmp++; if (ovPendiente !== 4'b0010 || ovOverrun !== 4'b0000) begin nErr++; $display("FAIL ovr_second: got %b/%b expected 0010/0000", ovPendiente, ovOverrun); end
    ivEstimulo = 4'b0000;
    tick();
    ivCuenta = 8'h40; ivEstimulo = 4'b0010;
    tick();
    nCmp++; if (ovOverrun !== 4'b0010) begin nErr++; $display("FAIL ovr_set: got %b expected 0010", ovOverrun); end
    ivEstimulo = 4'b0000; iAck = 1'b1;
    tick();
    iAck = 1'b0;
    tick();
    nCmp++; if (oCapturaFlag !== 1'b1 || ovCanal !== 2'd1 || ovCaptura !== 8'h20) begin nErr++; $display("FAIL ovr_kept: got %h/%h/%h expected 1/1/20", oCapturaFlag, ovCanal, ovCaptura); end
    iLimpiaOverrun = 1'b1;
    tick();
    iLimpiaOverrun = 1'b0;
    nCmp++; if (ovOverrun !== 4'b0000) begin nErr++; $display("FAIL ovr_clear: got %b expected 0000", ovOverrun); end
    ivCuenta = 8'h50; ivEstimulo = 4'b0010;
    tick();
    ivEstimulo = 4'b0000;
    tick();
    ivCuenta = 8'h60; ivEstimulo = 4'b0010; iLimpiaOverrun = 1'b1;
    tick();
    iLimpiaOverrun = 1'b0; ivEstimulo = 4'b0000;
    nCmp++; if (ovOverrun !== 4'b0010) begin nErr++; $display("FAIL ovr_wins_clear: got %b expected 0010", ovOverrun); end
    iAck = 1'b1;
    tick();
    iAck = 1'b0;
    tick();
    nCmp++; if (oCapturaFlag !== 1'b1 || ovCaptura !== 8'h50) begin nErr++; $display("FAIL ovr_slot50: got %h/%h expected 1/50", oCapturaFlag, ovCaptura); end
    iAck = 1'b1; iLimpiaOverrun = 1'b1;
    tick();
    iAck = 1'b0; iLimpiaOverrun = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [1:0] expOrder [5];
    expOrder = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    doReset();
    ivCuenta = 8'hA0; ivEstimulo = 4'b1111;
    tick();
    ivEstimulo = 4'b0000;
    tick();
    for (int i = 0; i < 5; i++) begin
      nCmp++; if (oCapturaFlag !== 1'b1 || ovCanal !== expOrder[i]) begin nErr++; $display("FAIL rr_order[%0d]: got %h/%h expected 1/%h", i, oCapturaFlag, ovCanal, expOrder[i]); end
      ivEstimulo = 4'b1111; iAck = 1'b1;
      tick();
      ivEstimulo = 4'b0000; iAck = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_present();
    doReset();
    ivCuenta = 8'h99; ivEstimulo = 4'b0100;
    tick();
    ivEstimulo = 4'b0000;
    tick();
    ivEstimulo = 4'b0001;
    tick();
    nCmp++; if (oCapturaFlag !== 1'b1 || ovCaptura !== 8'h99 || ovPendiente !== 4'b0001) begin nErr++; $display("FAIL rstp_setup: got %h/%h/%b expected 1/99/0001", oCapturaFlag, ovCaptura, ovPendiente); end
    #2;
    iReset = 1'b1; ivEstimulo = 4'b0100; ivCuenta = 8'h77;
    #1;
    nCmp++; if (oCapturaFlag !== 1'b0 || ovCaptura !== 8'h00 || ovCanal !== 2'd0) begin nErr++; $display("FAIL rstp_async: got %h/%h/%h expected 0/00/0", oCapturaFlag, ovCaptura, ovCanal); end
    nCmp++; if (ovPendiente !== 4'b0000 || ovOverrun !== 4'b0000) begin nErr++; $display("FAIL rstp_flags: got %b/%b expected 0000/0000", ovPendiente, ovOverrun); end
    iReset = 1'b0;
    tick();
    nCmp++; if (ovPendiente !== 4'b0100) begin nErr++; $display("FAIL rstp_high_edge: got %b expected 0100", ovPendiente); end
    ivEstimulo = 4'b0000;
    tick();
    nCmp++; if (ovCaptura !== 8'h77 || ovCanal !== 2'd2) begin nErr++; $display("FAIL rstp_capture: got %h/%h expected 77/2", ovCaptura, ovCanal); end
    iAck = 1'b1;
    tick();
    iAck = 1'b0;
  endtask

  task automatic test_wrap_enable();
    doReset();
    ivCuenta = 8'hFF; ivEstimulo = 4'b0001;
    tick();
    ivEstimulo = 4'b0000; ivCuenta = 8'h00;
    tick();
    nCmp++; if (oCapturaFlag !== 1'b1 || ovCaptura !== 8'hFF || ovCanal !== 2'd0) begin nErr++; $display("FAIL wrap_ff: got %h/%h/%h expected 1/ff/0", oCapturaFlag, ovCaptura, ovCanal); end
    iAck = 1'b1;
    tick();
    iAck = 1'b0; ivHabilita = 4'b1110; ivEstimulo = 4'b0001;
    tick();
    nCmp++; if (ovPendiente !== 4'b0000 || ovOverrun !== 4'b0000) begin nErr++; $display("FAIL enable_block: got %b/%b expected 0000/0000", ovPendiente, ovOverrun); end
    tick();
    nCmp++; if (oCapturaFlag !== 1'b0) begin nErr++; $display("FAIL enable_noflag: got %h expected 0", oCapturaFlag); end
    ivHabilita = 4'b1111; ivEstimulo = 4'b0000;
    tick();
    ivEstimulo = 4'b0001;
    tick();
    ivEstimulo = 4'b0000;
    tick();
    nCmp++; if (oCapturaFlag !== 1'b1 || ovCaptura !== 8'h00) begin nErr++; $display("FAIL wrap_00: got %h/%h expected 1/00", oCapturaFlag, ovCaptura); end
    iAck = 1'b1;
    tick();
    iAck = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_overrun();
    test_round_robin();
    test_reset_present();
    test_wrap_enable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

`default_nettype wire
